// File: rtl/vga_pkg.sv
// vga_pkg -- shared constants and types for the rectangle fill engine.
//   Frame geometry (HRES/VRES), framebuffer address/data widths,
//   Avalon register offsets, ctrl/status bit indices, FSM state enum,
//   and the end-coordinate clipping helper.
package vga_pkg;

  localparam int HRES  = 640;
  localparam int VRES  = 480;
  localparam int FB_AW = 19;
  localparam int FB_DW = 8;
  localparam int CW    = 11;   // coordinate width: {hi[2:0], lo}

  localparam logic [3:0] REG_XHI   = 4'd0;
  localparam logic [3:0] REG_XLO   = 4'd1;
  localparam logic [3:0] REG_YHI   = 4'd2;
  localparam logic [3:0] REG_YLO   = 4'd3;
  localparam logic [3:0] REG_WHI   = 4'd4;
  localparam logic [3:0] REG_WLO   = 4'd5;
  localparam logic [3:0] REG_HHI   = 4'd6;
  localparam logic [3:0] REG_HLO   = 4'd7;
  localparam logic [3:0] REG_COLOR = 4'd8;
  localparam logic [3:0] REG_CTRL  = 4'd9;

  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;
  localparam int STAT_BUSY  = 0;
  localparam int STAT_DONE  = 1;

  typedef enum logic [1:0] {IDLE, SETUP, RUN, FINISH} state_t;

  // min(org+len, lim); the sum is formed one bit wider so it cannot wrap.
  function automatic logic [CW-1:0] clip_end(input logic [CW-1:0] org,
                                             input logic [CW-1:0] len,
                                             input logic [CW-1:0] lim);
    logic [CW:0] sum;
    sum = {1'b0, org} + {1'b0, len};
    return (sum > {1'b0, lim}) ? lim : sum[CW-1:0];
  endfunction

endpackage

// File: rtl/vga_rect_addr_gen.sv
// vga_rect_addr_gen -- pixel walker for the fill engine.
//   Loads the clipped rectangle on i_load, then advances one pixel
//   (row-major) per i_step. Keeps the framebuffer address as a register
//   so the write port sees a registered address.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   i_load            latch origin/size and start at (x, y)
//   i_step            current beat accepted, advance to next pixel
//   i_x/i_y/i_w/i_h   rectangle origin and size (unclipped)
//   o_addr            framebuffer address of current pixel
//   o_last            current pixel is the last of the rectangle
module vga_rect_addr_gen
  import vga_pkg::*;
#(
  parameter int HRES = vga_pkg::HRES,
  parameter int VRES = vga_pkg::VRES,
  parameter int AW   = vga_pkg::FB_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load,
  input  logic          i_step,
  input  logic [CW-1:0] i_x,
  input  logic [CW-1:0] i_y,
  input  logic [CW-1:0] i_w,
  input  logic [CW-1:0] i_h,
  output logic [AW-1:0] o_addr,
  output logic          o_last
);

  logic [CW-1:0] r_x, r_x_end, r_y_end, r_cx, r_cy;
  logic [AW-1:0] r_row_base, r_addr;

  logic [CW-1:0] w_x_end, w_y_end;
  logic [AW-1:0] w_row_base_ld, w_row_base_nxt;
  logic          w_row_end;

  assign w_x_end = clip_end(i_x, i_w, CW'(HRES));
  assign w_y_end = clip_end(i_y, i_h, CW'(VRES));

  // y*640 as two shifts; only meaningful for y < VRES, otherwise the
  // parent never enters RUN and the truncated value is never used.
  assign w_row_base_ld  = (AW'(i_y) << 9) + (AW'(i_y) << 7);
  assign w_row_base_nxt = r_row_base + AW'(HRES);

  assign w_row_end = ((r_cx + CW'(1)) == r_x_end);
  assign o_last    = w_row_end && ((r_cy + CW'(1)) == r_y_end);
  assign o_addr    = r_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_x        <= '0;
      r_x_end    <= '0;
      r_y_end    <= '0;
      r_cx       <= '0;
      r_cy       <= '0;
      r_row_base <= '0;
      r_addr     <= '0;
    end else if (i_load) begin
      r_x        <= i_x;
      r_x_end    <= w_x_end;
      r_y_end    <= w_y_end;
      r_cx       <= i_x;
      r_cy       <= i_y;
      r_row_base <= w_row_base_ld;
      r_addr     <= w_row_base_ld + AW'(i_x);
    end else if (i_step) begin
      if (w_row_end) begin
        r_cx       <= r_x;
        r_cy       <= r_cy + CW'(1);
        r_row_base <= w_row_base_nxt;
        r_addr     <= w_row_base_nxt + AW'(r_x);
      end else begin
        r_cx   <= r_cx + CW'(1);
        r_addr <= r_addr + AW'(1);
      end
    end
  end

endmodule

// File: rtl/vga_rect_fill.sv
// vga_rect_fill -- Avalon-MM slave rectangle fill engine.
//   Software programs origin/size/colour and writes start; the block then
//   streams one framebuffer write per clipped pixel over valid/ready.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   chipselect/write/read       Avalon slave controls
//   address, writedata          register offset and write data
//   readdata                    registered read data, latency 1
//   wr_addr/wr_data/wr_valid    framebuffer write beat (registered)
//   wr_ready                    framebuffer accepts beat
//   done_irq                    one-cycle pulse on fill completion/abort
module vga_rect_fill
  import vga_pkg::*;
#(
  parameter int HRES = vga_pkg::HRES,
  parameter int VRES = vga_pkg::VRES,
  parameter int AW   = vga_pkg::FB_AW,
  parameter int DW   = vga_pkg::FB_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          chipselect,
  input  logic          write,
  input  logic          read,
  input  logic [3:0]    address,
  input  logic [7:0]    writedata,
  output logic [7:0]    readdata,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          wr_valid,
  input  logic          wr_ready,
  output logic          done_irq
);

  logic [7:0] r_xhi, r_xlo, r_yhi, r_ylo, r_whi, r_wlo, r_hhi, r_hlo, r_color;
  logic [7:0] r_readdata;
  logic       r_done, r_wr_valid, r_done_irq;
  state_t     r_state, w_state_nxt;

  logic [CW-1:0] w_x, w_y, w_w, w_h;
  logic          w_bus_wr, w_ctrl_wr, w_start, w_abort, w_busy;
  logic          w_empty, w_load, w_accept, w_last;

  assign w_x = {r_xhi[2:0], r_xlo};
  assign w_y = {r_yhi[2:0], r_ylo};
  assign w_w = {r_whi[2:0], r_wlo};
  assign w_h = {r_hhi[2:0], r_hlo};

  assign w_bus_wr  = chipselect && write;
  assign w_ctrl_wr = w_bus_wr && (address == REG_CTRL);
  assign w_start   = w_ctrl_wr && writedata[CTRL_START];
  assign w_abort   = w_ctrl_wr && writedata[CTRL_ABORT];
  assign w_busy    = (r_state != IDLE);

  // Nothing visible to draw: degenerate size or origin off-screen.
  assign w_empty = (w_w == '0) || (w_h == '0) ||
                   (w_x >= CW'(HRES)) || (w_y >= CW'(VRES));

  // r_wr_valid is only ever set in RUN, so an accept implies RUN.
  assign w_accept = r_wr_valid && wr_ready;

  vga_rect_addr_gen #(.HRES(HRES), .VRES(VRES), .AW(AW)) u_addr_gen (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_load),
    .i_step (w_accept),
    .i_x    (w_x),
    .i_y    (w_y),
    .i_w    (w_w),
    .i_h    (w_h),
    .o_addr (wr_addr),
    .o_last (w_last)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      IDLE:   if (w_start && !w_abort) w_state_nxt = SETUP;
      SETUP: begin
        w_load = 1'b1;
        w_state_nxt = (w_abort || w_empty) ? FINISH : RUN;
      end
      RUN:    if (w_abort || (w_accept && w_last)) w_state_nxt = FINISH;
      FINISH: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Valid and irq are registered copies of the next state, so the write
  // port and the interrupt see flop outputs; an abort drops valid on the
  // next edge even while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_wr_valid <= 1'b0;
      r_done_irq <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wr_valid <= (w_state_nxt == RUN);
      r_done_irq <= (w_state_nxt == FINISH);
      if (r_state == IDLE && w_start && !w_abort)
        r_done <= 1'b0;
      else if (r_state == FINISH)
        r_done <= 1'b1;
    end
  end

  // Geometry/colour registers; frozen while a fill is in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_xhi   <= '0;
      r_xlo   <= '0;
      r_yhi   <= '0;
      r_ylo   <= '0;
      r_whi   <= '0;
      r_wlo   <= '0;
      r_hhi   <= '0;
      r_hlo   <= '0;
      r_color <= '0;
    end else if (w_bus_wr && !w_busy) begin
      case (address)
        REG_XHI:   r_xhi   <= writedata;
        REG_XLO:   r_xlo   <= writedata;
        REG_YHI:   r_yhi   <= writedata;
        REG_YLO:   r_ylo   <= writedata;
        REG_WHI:   r_whi   <= writedata;
        REG_WLO:   r_wlo   <= writedata;
        REG_HHI:   r_hhi   <= writedata;
        REG_HLO:   r_hlo   <= writedata;
        REG_COLOR: r_color <= writedata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_readdata <= '0;
    end else if (chipselect && read) begin
      case (address)
        REG_XHI:   r_readdata <= r_xhi;
        REG_XLO:   r_readdata <= r_xlo;
        REG_YHI:   r_readdata <= r_yhi;
        REG_YLO:   r_readdata <= r_ylo;
        REG_WHI:   r_readdata <= r_whi;
        REG_WLO:   r_readdata <= r_wlo;
        REG_HHI:   r_readdata <= r_hhi;
        REG_HLO:   r_readdata <= r_hlo;
        REG_COLOR: r_readdata <= r_color;
        REG_CTRL:  r_readdata <= {6'b0, r_done, w_busy};
        default:   r_readdata <= '0;
      endcase
    end else begin
      r_readdata <= '0;
    end
  end

  assign readdata = r_readdata;
  assign wr_valid = r_wr_valid;
  assign wr_data  = DW'(r_color);
  assign done_irq = r_done_irq;

endmodule
